// File: rtl/icache_pkg.sv
// Shared geometry and FSM encoding for the 16-set, 4-way instruction-cache tag path.
package icache_pkg;
  localparam int NUM_SETS  = 16;
  localparam int SET_BITS  = 4;
  localparam int NUM_WAYS  = 4;
  localparam int WAY_BITS  = 2;
  localparam int WAY_WIDTH = 8;
  localparam int VALID_BIT = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  function automatic logic [NUM_WAYS-1:0] row_valids(input logic [NUM_WAYS*WAY_WIDTH-1:0] row);
    logic [NUM_WAYS-1:0] v;
    for (int w = 0; w < NUM_WAYS; w++) v[w] = row[w*WAY_WIDTH + VALID_BIT];
    return v;
  endfunction
endpackage

// File: rtl/icache_victim_sel.sv
// Victim pick for a refill: lowest invalid way first, else the per-set round-robin pointer.
module icache_victim_sel
  import icache_pkg::*;
(
  input  logic                gated_clk,
  input  logic                arst_n,
  input  logic [NUM_WAYS-1:0] valids,
  input  logic [SET_BITS-1:0] rd_set,
  input  logic                wr_en,
  input  logic [SET_BITS-1:0] wr_set,
  input  logic [WAY_BITS-1:0] wr_ptr,
  output logic [WAY_BITS-1:0] victim
);
  logic [WAY_BITS-1:0] ptr [NUM_SETS];

  always_ff @(posedge gated_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int s = 0; s < NUM_SETS; s++) ptr[s] <= '0;
    end else if (wr_en) begin
      ptr[wr_set] <= wr_ptr;
    end
  end

  // Scan from the top so the lowest-index invalid way is the last to win.
  always_comb begin
    victim = ptr[rd_set];
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (!valids[w]) victim = WAY_BITS'(w);
    end
  end
endmodule

// File: rtl/tag_hit_refill_ctrl.sv
// Tag compare plus miss-refill FSM sitting behind the tag SRAM read stage.
module tag_hit_refill_ctrl
  import icache_pkg::*;
#(
  parameter int TAG_WIDTH = 7
) (
  input  logic                          gated_clk,
  input  logic                          arst_n,
  input  logic                          i_valid,
  input  logic [TAG_WIDTH-1:0]          i_tag,
  input  logic [SET_BITS-1:0]           i_set,
  input  logic [NUM_WAYS*WAY_WIDTH-1:0] i_row,
  output logic                          o_ready,
  output logic                          o_valid,
  output logic                          o_hit,
  output logic [WAY_BITS-1:0]           o_hit_way,
  output logic [SET_BITS-1:0]           o_set,
  output logic                          o_mem_req,
  output logic [SET_BITS-1:0]           o_mem_set,
  output logic [TAG_WIDTH-1:0]          o_mem_tag,
  input  logic                          i_mem_ack,
  output logic                          o_w_valid,
  output logic [SET_BITS-1:0]           o_w_addr,
  output logic [NUM_WAYS*WAY_WIDTH-1:0] o_w_data,
  output logic [NUM_WAYS-1:0]           o_w_wmask
);
  state_t              state;
  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  logic [WAY_BITS-1:0] victim;
  logic [WAY_BITS-1:0] victim_p1;

  function automatic logic [NUM_WAYS*WAY_WIDTH-1:0] fill_row(input logic [TAG_WIDTH-1:0] tag);
    logic [WAY_WIDTH-1:0] entry;
    entry = '0;
    entry[VALID_BIT] = 1'b1;
    entry[TAG_WIDTH-1:0] = tag;
    return {NUM_WAYS{entry}};
  endfunction

  // Stage 0: combinational compare; lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (i_row[w*WAY_WIDTH + VALID_BIT] && (i_row[w*WAY_WIDTH +: TAG_WIDTH] == i_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  icache_victim_sel u_victim_sel (
    .gated_clk (gated_clk),
    .arst_n    (arst_n),
    .valids    (row_valids(i_row)),
    .rd_set    (i_set),
    .wr_en     (state == FILL),
    .wr_set    (o_w_addr),
    .wr_ptr    (victim_p1 + WAY_BITS'(1)),
    .victim    (victim)
  );

  // Stage 1: registered result and refill sequencing.
  always_ff @(posedge gated_clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_hit     <= 1'b0;
      o_hit_way <= '0;
      o_set     <= '0;
      o_mem_req <= 1'b0;
      o_mem_set <= '0;
      o_mem_tag <= '0;
      o_w_valid <= 1'b0;
      o_w_addr  <= '0;
      o_w_data  <= '0;
      o_w_wmask <= '0;
      victim_p1 <= '0;
    end else begin
      o_valid   <= 1'b0;
      o_w_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            o_valid   <= 1'b1;
            o_hit     <= hit;
            o_hit_way <= hit_way;
            o_set     <= i_set;
            if (!hit) begin
              state     <= REQ;
              o_ready   <= 1'b0;
              o_mem_req <= 1'b1;
              o_mem_set <= i_set;
              o_mem_tag <= i_tag;
              victim_p1 <= victim;
            end
          end
        end
        REQ: begin
          if (i_mem_ack) begin
            state     <= FILL;
            o_mem_req <= 1'b0;
            o_w_valid <= 1'b1;
            o_w_addr  <= o_mem_set;
            o_w_data  <= fill_row(o_mem_tag);
            o_w_wmask <= NUM_WAYS'(1) << victim_p1;
          end
        end
        FILL: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tag_hit_refill_ctrl.sv
// Randomized and directed bench for tag_hit_refill_ctrl against a transaction-level model.
module tb_tag_hit_refill_ctrl;
  logic        gated_clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        i_valid = 1'b0;
  logic [6:0]  i_tag = '0;
  logic [3:0]  i_set = '0;
  logic [31:0] i_row = '0;
  logic        i_mem_ack = 1'b0;
  logic        o_ready, o_valid, o_hit, o_mem_req, o_w_valid;
  logic [1:0]  o_hit_way;
  logic [3:0]  o_set, o_mem_set, o_w_addr, o_w_wmask;
  logic [6:0]  o_mem_tag;
  logic [31:0] o_w_data;

  int total = 0;
  int bad = 0;

  tag_hit_refill_ctrl #(.TAG_WIDTH(7)) dut (
    .gated_clk(gated_clk), .arst_n(arst_n), .i_valid(i_valid), .i_tag(i_tag),
    .i_set(i_set), .i_row(i_row), .o_ready(o_ready), .o_valid(o_valid),
    .o_hit(o_hit), .o_hit_way(o_hit_way), .o_set(o_set), .o_mem_req(o_mem_req),
    .o_mem_set(o_mem_set), .o_mem_tag(o_mem_tag), .i_mem_ack(i_mem_ack),
    .o_w_valid(o_w_valid), .o_w_addr(o_w_addr), .o_w_data(o_w_data), .o_w_wmask(o_w_wmask)
  );

  always #5 gated_clk = ~gated_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_hit(input logic [31:0] row, input logic [6:0] tag);
    for (int w = 0; w < 4; w++)
      if (row[w*8+7] && row[w*8 +: 7] == tag) return w;
    return -1;
  endfunction

  // Transaction model: pending refill described by (set, tag, victim) plus a phase count.
  int          phase = 0;
  int          ptrs [16];
  int          r_set = 0, r_tag = 0, r_vic = 0;
  logic        m_ready = 1'b1, m_valid = 1'b0, m_hit = 1'b0, m_req = 1'b0, m_wv = 1'b0;
  int          m_way = 0, m_set = 0;
  logic [31:0] m_wdata = '0;

  always @(posedge gated_clk or negedge arst_n) begin
    if (!arst_n) begin
      phase = 0; m_ready = 1; m_valid = 0; m_hit = 0; m_way = 0; m_set = 0;
      m_req = 0; m_wv = 0;
      for (int s = 0; s < 16; s++) ptrs[s] = 0;
    end else begin
      m_valid = 0;
      if (phase == 2) begin
        ptrs[r_set] = (r_vic + 1) % 4;
        m_wv = 0; m_ready = 1; phase = 0;
      end else if (phase == 1) begin
        if (i_mem_ack) begin
          m_req = 0; m_wv = 1; phase = 2;
          m_wdata = {4{8'h80 | 8'(r_tag)}};
        end
      end else if (i_valid) begin
        int h;
        h = find_hit(i_row, i_tag);
        m_valid = 1; m_hit = (h >= 0); m_way = (h >= 0) ? h : 0; m_set = i_set;
        if (h < 0) begin
          r_vic = -1;
          for (int w = 3; w >= 0; w--) if (!i_row[w*8+7]) r_vic = w;
          if (r_vic < 0) r_vic = ptrs[i_set];
          r_set = i_set; r_tag = i_tag;
          phase = 1; m_ready = 0; m_req = 1;
        end
      end
    end
  end

  always @(negedge gated_clk) begin
    check("ready", 32'(o_ready), 32'(m_ready));
    check("valid", 32'(o_valid), 32'(m_valid));
    if (m_valid) begin
      check("hit", 32'(o_hit), 32'(m_hit));
      check("hit_way", 32'(o_hit_way), 32'(m_way));
      check("set", 32'(o_set), 32'(m_set));
    end
    check("mem_req", 32'(o_mem_req), 32'(m_req));
    if (m_req) begin
      check("mem_set", 32'(o_mem_set), 32'(r_set));
      check("mem_tag", 32'(o_mem_tag), 32'(r_tag));
    end
    check("w_valid", 32'(o_w_valid), 32'(m_wv));
    if (m_wv) begin
      check("w_addr", 32'(o_w_addr), 32'(r_set));
      check("w_data", o_w_data, m_wdata);
      check("w_wmask", 32'(o_w_wmask), 32'(1 << r_vic));
    end
  end

  task automatic lookup(input logic [3:0] set, input logic [6:0] tag, input logic [31:0] row);
    i_valid = 1; i_set = set; i_tag = tag; i_row = row;
    @(posedge gated_clk); #1;
    i_valid = 0;
  endtask

  task automatic ack_refill(input logic [3:0] set, input logic [31:0] data, input logic [3:0] mask);
    i_mem_ack = 1;
    @(posedge gated_clk); #1;
    i_mem_ack = 0;
    check("lit_w_valid", 32'(o_w_valid), 32'd1);
    check("lit_w_addr", 32'(o_w_addr), 32'(set));
    check("lit_w_data", o_w_data, data);
    check("lit_w_wmask", 32'(o_w_wmask), 32'(mask));
    check("lit_req_drop", 32'(o_mem_req), 32'd0);
    @(posedge gated_clk); #1;
    check("lit_ready_back", 32'(o_ready), 32'd1);
    check("lit_w_off", 32'(o_w_valid), 32'd0);
  endtask

  initial begin
    #1 arst_n = 0;
    #2;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_req", 32'(o_mem_req), 32'd0);
    check("rst_wv", 32'(o_w_valid), 32'd0);
    check("rst_way", 32'(o_hit_way), 32'd0);
    repeat (2) @(posedge gated_clk);
    #1 arst_n = 1;
    @(posedge gated_clk); #1;

    lookup(4'd3, 7'h15, 32'h0095_0000);
    check("lit_valid", 32'(o_valid), 32'd1);
    check("lit_hit", 32'(o_hit), 32'd1);
    check("lit_way2", 32'(o_hit_way), 32'd2);
    check("lit_set3", 32'(o_set), 32'd3);
    check("lit_ready", 32'(o_ready), 32'd1);

    lookup(4'd1, 7'h0A, 32'h0000_8A8A);
    check("lit_lowest_way", 32'(o_hit_way), 32'd0);
    check("lit_hit_b", 32'(o_hit), 32'd1);
    lookup(4'd1, 7'h0A, 32'h0000_0A0A);
    check("lit_nohit", 32'(o_hit), 32'd0);
    ack_refill(4'd1, 32'h8A8A_8A8A, 4'b0001);

    lookup(4'd5, 7'h21, 32'h8080_0080);
    check("lit_miss_valid", 32'(o_valid), 32'd1);
    check("lit_miss_hit", 32'(o_hit), 32'd0);
    repeat (3) begin
      check("lit_req", 32'(o_mem_req), 32'd1);
      check("lit_mset", 32'(o_mem_set), 32'd5);
      check("lit_mtag", 32'(o_mem_tag), 32'h21);
      @(posedge gated_clk); #1;
    end
    ack_refill(4'd5, 32'hA1A1_A1A1, 4'b0010);

    for (int k = 0; k < 5; k++) begin
      lookup(4'd9, 7'(8'h10 + k), 32'h8181_8181);
      ack_refill(4'd9, {4{8'h90 + 8'(k)}}, 4'(1 << (k % 4)));
    end

    lookup(4'd7, 7'h33, 32'h0000_0000);
    for (int k = 0; k < 10; k++) begin
      i_valid = 1; i_set = 4'd2; i_tag = 7'h15; i_row = 32'h0095_0000;
      @(posedge gated_clk); #1;
      check("lit_busy_novalid", 32'(o_valid), 32'd0);
      check("lit_busy_req", 32'(o_mem_req), 32'd1);
      check("lit_busy_nowrite", 32'(o_w_valid), 32'd0);
    end
    i_valid = 0;
    arst_n = 0;
    #1;
    check("lit_arst_req", 32'(o_mem_req), 32'd0);
    check("lit_arst_ready", 32'(o_ready), 32'd1);
    @(posedge gated_clk); #1;
    arst_n = 1;
    i_mem_ack = 1;
    @(posedge gated_clk); #1;
    i_mem_ack = 0;
    check("lit_late_ack", 32'(o_w_valid), 32'd0);
    lookup(4'd9, 7'h44, 32'h8181_8181);
    ack_refill(4'd9, 32'hC4C4_C4C4, 4'b0001);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] row;
      logic [6:0]  tag;
      int          w;
      tag = 7'($urandom_range(0, 7));
      row = $urandom;
      if ($urandom_range(0, 1) == 1) row |= 32'h8080_8080;
      if ($urandom_range(0, 2) == 0) begin
        w = $urandom_range(0, 3);
        row[w*8 +: 8] = {1'b1, tag};
      end
      i_valid   = ($urandom_range(0, 2) != 0);
      i_set     = 4'($urandom_range(0, 3));
      i_tag     = tag;
      i_row     = row;
      i_mem_ack = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 299) == 0) begin
        arst_n = 0;
        #2 arst_n = 1;
      end
      @(posedge gated_clk); #1;
    end
    i_valid = 0; i_mem_ack = 0;
    repeat (2) @(posedge gated_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
